// File: rtl/axi_lite_rr_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master port among C_NUM_REQ
// requesters, one outstanding transaction at a time.
module axi_lite_rr_arbiter #(
  parameter int C_NUM_REQ          = 4,
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32
) (
  input  logic M_AXI_ACLK,
  input  logic M_AXI_ARESET,

  input  logic [C_NUM_REQ-1:0] REQ_VALID,
  input  logic [C_NUM_REQ-1:0] REQ_WRITE,
  input  logic [C_NUM_REQ*C_M_AXI_ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [C_NUM_REQ*C_M_AXI_DATA_WIDTH-1:0] REQ_WDATA,
  input  logic [C_NUM_REQ*C_M_AXI_DATA_WIDTH/8-1:0] REQ_WSTRB,
  output logic [C_NUM_REQ-1:0] REQ_ACK,
  output logic [C_NUM_REQ-1:0] RESP_VALID,
  output logic [C_M_AXI_DATA_WIDTH-1:0] RESP_RDATA,
  output logic RESP_ERR,
  output logic BUSY,
  output logic [15:0] ERR_COUNT,

  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic [2:0] M_AXI_AWPROT,
  output logic M_AXI_AWVALID,
  input  logic M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic M_AXI_WVALID,
  input  logic M_AXI_WREADY,
  input  logic [1:0] M_AXI_BRESP,
  input  logic M_AXI_BVALID,
  output logic M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [2:0] M_AXI_ARPROT,
  output logic M_AXI_ARVALID,
  input  logic M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0] M_AXI_RRESP,
  input  logic M_AXI_RVALID,
  output logic M_AXI_RREADY
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;
  localparam int PW = $clog2(C_NUM_REQ);
  localparam logic [PW:0] NREQ = (PW+1)'(C_NUM_REQ);
  localparam logic [PW-1:0] LAST = PW'(C_NUM_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_WR_RESP,
    S_RD_REQ,
    S_RD_RESP,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]        grant_q, grant_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [DW-1:0]        wdata_q, wdata_d;
  logic [SW-1:0]        strb_q, strb_d;
  logic [C_NUM_REQ-1:0] ack_q, ack_d;
  logic                 aw_done_q, aw_done_d;
  logic                 w_done_q, w_done_d;
  logic [DW-1:0]        rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic [15:0]          err_cnt_q, err_cnt_d;

  logic aw_hs;
  logic w_hs;
  logic unused_resp;

  assign aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs  = M_AXI_WVALID && M_AXI_WREADY;
  assign unused_resp = M_AXI_BRESP[0] ^ M_AXI_RRESP[0];

  // Scan starts at rr_ptr and wraps modulo C_NUM_REQ.
  logic          found;
  logic [PW-1:0] win;
  logic [PW:0]   scan;

  always_comb begin
    found = 1'b0;
    win   = '0;
    scan  = '0;
    for (int i = 0; i < C_NUM_REQ; i++) begin
      scan = {1'b0, rr_ptr_q} + (PW+1)'(i);
      if (scan >= NREQ) scan = scan - NREQ;
      if (!found && REQ_VALID[scan[PW-1:0]]) begin
        found = 1'b1;
        win   = scan[PW-1:0];
      end
    end
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) state_q <= S_IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (found)
          state_d = REQ_WRITE[win] ? S_WR_REQ : S_RD_REQ;
      S_WR_REQ:
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs))
          state_d = S_WR_RESP;
      S_WR_RESP: if (M_AXI_BVALID)  state_d = S_DONE;
      S_RD_REQ:  if (M_AXI_ARREADY) state_d = S_RD_RESP;
      S_RD_RESP: if (M_AXI_RVALID)  state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    M_AXI_AWVALID = (state_q == S_WR_REQ) && !aw_done_q;
    M_AXI_WVALID  = (state_q == S_WR_REQ) && !w_done_q;
    M_AXI_ARVALID = (state_q == S_RD_REQ);
    M_AXI_BREADY  = (state_q == S_WR_RESP);
    M_AXI_RREADY  = (state_q == S_RD_RESP);
    BUSY          = (state_q != S_IDLE);
    RESP_VALID    = '0;
    if (state_q == S_DONE) RESP_VALID[grant_q] = 1'b1;
  end

  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    ack_d     = '0;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (found) begin
          grant_d    = win;
          addr_d     = REQ_ADDR[win*AW +: AW];
          wdata_d    = REQ_WDATA[win*DW +: DW];
          strb_d     = REQ_WSTRB[win*SW +: SW];
          ack_d[win] = 1'b1;
          rr_ptr_d   = (win == LAST) ? '0 : win + 1'b1;
        end
      end
      S_WR_REQ: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
      end
      S_WR_RESP:
        if (M_AXI_BVALID) begin
          rdata_d = '0;
          err_d   = M_AXI_BRESP[1];
        end
      S_RD_RESP:
        if (M_AXI_RVALID) begin
          rdata_d = M_AXI_RDATA;
          err_d   = M_AXI_RRESP[1];
        end
      S_DONE:
        if (err_q && err_cnt_q != 16'hFFFF)
          err_cnt_d = err_cnt_q + 16'd1;
      default: ;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      ack_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      ack_q     <= ack_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign REQ_ACK      = ack_q;
  assign RESP_RDATA   = rdata_q;
  assign RESP_ERR     = err_q;
  assign ERR_COUNT    = err_cnt_q;
  assign M_AXI_AWADDR = addr_q;
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_WDATA  = wdata_q;
  assign M_AXI_WSTRB  = strb_q;
  assign M_AXI_ARADDR = addr_q;
  assign M_AXI_ARPROT = 3'b000;

endmodule

// File: tb/tb_axi_lite_rr_arbiter.sv
// Scoreboard bench for axi_lite_rr_arbiter with a delay-programmable
// AXI4-Lite slave model.
module tb_axi_lite_rr_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid, req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N*SW-1:0] req_wstrb;
  logic [N-1:0]    req_ack, resp_valid;
  logic [DW-1:0]   resp_rdata;
  logic            resp_err, busy;
  logic [15:0]     err_count;

  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, awready, wvalid, wready;
  logic [DW-1:0] wdata, rdata;
  logic [SW-1:0] wstrb;
  logic [1:0]    bresp, rresp;
  logic          bvalid, bready, arvalid, arready;
  logic          rvalid, rready;

  axi_lite_rr_arbiter #(
    .C_NUM_REQ(N),
    .C_M_AXI_ADDR_WIDTH(AW),
    .C_M_AXI_DATA_WIDTH(DW)
  ) dut (
    .M_AXI_ACLK(clk),
    .M_AXI_ARESET(rst),
    .REQ_VALID(req_valid),
    .REQ_WRITE(req_write),
    .REQ_ADDR(req_addr),
    .REQ_WDATA(req_wdata),
    .REQ_WSTRB(req_wstrb),
    .REQ_ACK(req_ack),
    .RESP_VALID(resp_valid),
    .RESP_RDATA(resp_rdata),
    .RESP_ERR(resp_err),
    .BUSY(busy),
    .ERR_COUNT(err_count),
    .M_AXI_AWADDR(awaddr),
    .M_AXI_AWPROT(awprot),
    .M_AXI_AWVALID(awvalid),
    .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata),
    .M_AXI_WSTRB(wstrb),
    .M_AXI_WVALID(wvalid),
    .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp),
    .M_AXI_BVALID(bvalid),
    .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr),
    .M_AXI_ARPROT(arprot),
    .M_AXI_ARVALID(arvalid),
    .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata),
    .M_AXI_RRESP(rresp),
    .M_AXI_RVALID(rvalid),
    .M_AXI_RREADY(rready)
  );

  typedef struct {
    int            gnt;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] slave_rd(input logic [AW-1:0] a);
    return (a == 32'h8800_0004) ? 32'h2222_2222 : ~a;
  endfunction

  // slave model
  int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
  logic [1:0] s_bresp = 2'b00, s_rresp = 2'b00;
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
  int n_aw = 0, n_w = 0, n_ar = 0, n_b = 0, n_r = 0;
  logic aw_got = 0, w_got = 0, b_pend = 0, r_pend = 0;
  logic [AW-1:0] r_addr = '0, last_awaddr = '0;
  logic [DW-1:0] last_wdata = '0;
  logic [SW-1:0] last_wstrb = '0;

  assign awready = awvalid && (aw_cnt >= aw_dly);
  assign wready  = wvalid && (w_cnt >= w_dly);
  assign arready = arvalid && (ar_cnt >= ar_dly);
  assign bvalid  = b_pend && (b_cnt >= b_dly);
  assign rvalid  = r_pend && (r_cnt >= r_dly);
  assign bresp   = s_bresp;
  assign rresp   = s_rresp;
  assign rdata   = r_pend ? slave_rd(r_addr) : '0;

  always @(posedge clk) begin
    if (rst) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
      b_cnt <= 0; r_cnt <= 0;
      aw_got <= 0; w_got <= 0;
      b_pend <= 0; r_pend <= 0;
    end else begin
      aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
      ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
      if (awvalid && awready) begin
        n_aw <= n_aw + 1;
        aw_got <= 1;
        last_awaddr <= awaddr;
      end
      if (wvalid && wready) begin
        n_w <= n_w + 1;
        w_got <= 1;
        last_wdata <= wdata;
        last_wstrb <= wstrb;
      end
      if ((aw_got || (awvalid && awready)) &&
          (w_got || (wvalid && wready))) begin
        aw_got <= 0;
        w_got  <= 0;
        b_pend <= 1;
        b_cnt  <= 0;
      end else if (b_pend && !(bvalid && bready)) begin
        b_cnt <= b_cnt + 1;
      end
      if (bvalid && bready) begin
        b_pend <= 0;
        n_b <= n_b + 1;
      end
      if (arvalid && arready) begin
        n_ar <= n_ar + 1;
        r_pend <= 1;
        r_cnt <= 0;
        r_addr <= araddr;
      end else if (r_pend && !(rvalid && rready)) begin
        r_cnt <= r_cnt + 1;
      end
      if (rvalid && rready) begin
        r_pend <= 0;
        n_r <= n_r + 1;
      end
    end
  end

  // monitor: responses, ACK shape, VALID stability
  logic [N-1:0] p_ack = '0;
  logic p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;
  int n_wonly = 0, n_awonly = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (req_ack != 0) chk("ack_onehot", $onehot(req_ack), 1);
      if (p_ack != 0) chk("ack_pulse", req_ack, 0);
      if (p_awv && !p_awr) chk("awv_hold", awvalid, 1);
      if (p_awv && p_awr) chk("awv_drop", awvalid, 0);
      if (p_wv && !p_wr) chk("wv_hold", wvalid, 1);
      if (p_wv && p_wr) chk("wv_drop", wvalid, 0);
      if (p_arv && !p_arr) chk("arv_hold", arvalid, 1);
      if (p_arv && p_arr) chk("arv_drop", arvalid, 0);
      if (awvalid || arvalid) chk("aw_ar_overlap", awvalid & arvalid, 0);
      if (wvalid && !awvalid) n_wonly <= n_wonly + 1;
      if (awvalid && !wvalid) n_awonly <= n_awonly + 1;
      if (resp_valid != 0) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected", resp_valid, 0);
        end else begin
          chk("resp_gnt", resp_valid, 1 << sb[0].gnt);
          chk("resp_rdata", resp_rdata, sb[0].rdata);
          chk("resp_err", resp_err, sb[0].err);
          void'(sb.pop_front());
        end
      end
      p_ack <= req_ack;
      p_awv <= awvalid; p_awr <= awready;
      p_wv  <= wvalid;  p_wr  <= wready;
      p_arv <= arvalid; p_arr <= arready;
    end else begin
      p_ack <= '0;
      p_awv <= 0; p_awr <= 0;
      p_wv  <= 0; p_wr  <= 0;
      p_arv <= 0; p_arr <= 0;
    end
  end

  task automatic drive(input int idx, input logic wr,
                       input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [SW-1:0] s, input logic err);
    exp_t e;
    req_valid[idx] = 1'b1;
    req_write[idx] = wr;
    req_addr[idx*AW +: AW]  = a;
    req_wdata[idx*DW +: DW] = d;
    req_wstrb[idx*SW +: SW] = s;
    e.gnt   = idx;
    e.rdata = wr ? '0 : slave_rd(a);
    e.err   = err;
    sb.push_back(e);
  endtask

  task automatic req(input int idx, input logic wr,
                     input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input logic [SW-1:0] s, input logic err,
                     output int lat, output logic [4:0] v);
    @(posedge clk); #1;
    drive(idx, wr, a, d, s, err);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!req_ack[idx] && lat < 100);
    v = {awvalid, wvalid, awready, wready, arvalid};
    chk("ack_seen", req_ack[idx], 1);
    @(posedge clk); #1;
    req_valid[idx] = 1'b0;
  endtask

  task automatic wait_ack(input string tag, input logic [N-1:0] exp);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_ack == 0 && n < 100);
    chk(tag, req_ack, exp);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", (sb.size() == 0) && !busy, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int b_aw, b_w, b_ar, b_b, b_r, b_wo, b_ao;
    logic [4:0] v;
    exp_t e;

    rst = 1'b1;
    req_valid = '0; req_write = '0;
    req_addr = '0; req_wdata = '0; req_wstrb = '0;

    // all four requesters held from reset: odd ones write
    for (int i = 0; i < N; i++) begin
      req_write[i] = i[0];
      req_addr[i*AW +: AW]  = 32'h1000 + 32'(4 * i);
      req_wdata[i*DW +: DW] = 32'hA0A0_0000 + 32'(i);
      req_wstrb[i*SW +: SW] = 4'hF;
    end
    req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      e.gnt   = k % N;
      e.rdata = (k % 2 == 1) ? '0 : ~(32'h1000 + 32'(4 * (k % N)));
      e.err   = 1'b0;
      sb.push_back(e);
    end

    repeat (3) @(negedge clk);
    chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready}, 0);
    chk("rst_ack", req_ack, 0);
    chk("rst_resp", resp_valid, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_err", resp_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_errcnt", err_count, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    b_aw = n_aw; b_ar = n_ar;
    for (int k = 0; k < 8; k++)
      wait_ack("rr_gnt", 4'(1 << (k % N)));
    @(posedge clk); #1;
    req_valid = '0;
    wait_idle();
    chk("rr_aw_count", n_aw - b_aw, 4);
    chk("rr_ar_count", n_ar - b_ar, 4);

    // single write, slave ready at once
    b_b = n_b;
    req(0, 1'b1, 32'h8800_0000, 32'h1111_1111, 4'hF, 1'b0, lat, v);
    chk("wr_ack_latency", lat, 2);
    chk("wr_valids_at_ack", v, 5'b11110);
    wait_idle();
    chk("wr_awaddr", last_awaddr, 32'h8800_0000);
    chk("wr_wdata", last_wdata, 32'h1111_1111);
    chk("wr_wstrb", last_wstrb, 4'hF);
    chk("wr_b_count", n_b - b_b, 1);

    // single read with delayed RVALID
    r_dly = 3;
    b_ar = n_ar; b_r = n_r;
    req(2, 1'b0, 32'h8800_0004, '0, '0, 1'b0, lat, v);
    chk("rd_ack_latency", lat, 2);
    chk("rd_arvalid_at_ack", v, 5'b00001);
    wait_idle();
    chk("rd_ar_count", n_ar - b_ar, 1);
    chk("rd_r_count", n_r - b_r, 1);
    r_dly = 0;

    // AW/W skew: W late, AW late, both together
    for (int c = 0; c < 3; c++) begin
      aw_dly = (c == 0) ? 0 : (c == 1) ? 4 : 2;
      w_dly  = (c == 0) ? 4 : (c == 1) ? 0 : 2;
      b_aw = n_aw; b_w = n_w; b_b = n_b;
      b_wo = n_wonly; b_ao = n_awonly;
      req(3, 1'b1, 32'h4000 + 32'(c), 32'h5500 + 32'(c), 4'h3,
          1'b0, lat, v);
      wait_idle();
      chk("skew_aw_count", n_aw - b_aw, 1);
      chk("skew_w_count", n_w - b_w, 1);
      chk("skew_b_count", n_b - b_b, 1);
      chk("skew_w_only", (n_wonly - b_wo) > 0, c == 0);
      chk("skew_aw_only", (n_awonly - b_ao) > 0, c == 1);
    end
    aw_dly = 0; w_dly = 0;

    // error responses
    s_bresp = 2'b10;
    req(1, 1'b1, 32'h5000, 32'h1, 4'hF, 1'b1, lat, v);
    wait_idle();
    req(1, 1'b1, 32'h5004, 32'h2, 4'hF, 1'b1, lat, v);
    wait_idle();
    s_bresp = 2'b00;
    s_rresp = 2'b11;
    req(0, 1'b0, 32'h5008, '0, '0, 1'b1, lat, v);
    wait_idle();
    s_rresp = 2'b00;
    chk("err_count", err_count, 3);

    // reset during WR_RESP
    b_dly = 6;
    req(2, 1'b1, 32'h6000, 32'h6, 4'hF, 1'b0, lat, v);
    lat = 0;
    while (!bready && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("bready_reached", bready, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    b_dly = 0;
    @(negedge clk);
    chk("abort_valids", {awvalid, wvalid, arvalid, bready, rready}, 0);
    chk("abort_busy", busy, 0);
    chk("abort_resp", resp_valid, 0);
    chk("abort_errcnt", err_count, 0);

    // rr_ptr back at 0: requester 1 must beat requester 3
    @(posedge clk); #1;
    drive(1, 1'b0, 32'h8800_0004, '0, '0, 1'b0);
    drive(3, 1'b1, 32'h7000, 32'h7, 4'hF, 1'b0);
    wait_ack("post_rst_gnt1", 4'b0010);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    wait_ack("post_rst_gnt3", 4'b1000);
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_lite_rr_arbiter.md
Name: axi_lite_rr_arbiter

Overview:
- Shares one AXI4-Lite master port among C_NUM_REQ user requesters (config sequencers, register pokers, GPIO-triggered test engines).
- Uses round-robin arbitration with one outstanding transaction at a time.
- Accepts a simple request/ack/response interface per requester and drives all five AXI4-Lite channels.
- Returns read data and error status to the winning requester.

Parameters:
- C_NUM_REQ, 4, number of requesters (2..8).
- C_M_AXI_ADDR_WIDTH, 32, AXI address width.
- C_M_AXI_DATA_WIDTH, 32, AXI data width.

Ports:
- M_AXI_ACLK  in  1  clock.
- M_AXI_ARESET  in  1  reset. One clock domain; reset is synchronous and active-high.
- REQ_VALID  in  C_NUM_REQ  per-requester request pending.
- REQ_WRITE  in  C_NUM_REQ  1 = write, 0 = read.
- REQ_ADDR  in  C_NUM_REQ*ADDR_W  packed addresses; requester i occupies slice [i*W +: W].
- REQ_WDATA  in  C_NUM_REQ*DATA_W  packed write data.
- REQ_WSTRB  in  C_NUM_REQ*DATA_W/8  packed byte strobes.
- REQ_ACK  out  C_NUM_REQ  one-hot, 1-cycle pulse: request accepted.
- RESP_VALID  out  C_NUM_REQ  one-hot, 1-cycle pulse: transaction complete.
- RESP_RDATA  out  DATA_W  read data; 0 for writes.
- RESP_ERR  out  1  xRESP[1] of the completed transaction.
- BUSY  out  1  state != IDLE.
- ERR_COUNT  out  16  saturating count of error responses.
- M_AXI_AW*/W*/B*/AR*/R*: standard AXI4-Lite master signal set.
  - AWPROT and ARPROT tied to 0.

Behaviour:
- Reset values (reset has priority over everything):
  - AWVALID, WVALID, ARVALID, BREADY, RREADY = 0.
  - REQ_ACK, RESP_VALID = 0; RESP_RDATA = 0; RESP_ERR = 0; BUSY = 0; ERR_COUNT = 0.
  - State = IDLE; rr_ptr = 0.
- Reset mid-transaction aborts immediately. The slave/interconnect shares the same reset.
- State machine: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
- IDLE:
  - If any REQ_VALID is set, the winner is the first set bit scanning rr_ptr, rr_ptr+1, ... with wrap modulo C_NUM_REQ.
  - Latch the winner's write flag, addr, wdata, strb and the grant index.
  - rr_ptr <= winner+1 (wraps to 0 after C_NUM_REQ-1).
  - Next cycle: REQ_ACK[winner] = 1 for exactly one cycle, and state moves to WR_REQ or RD_REQ.
- Requester rules:
  - Hold REQ_VALID and payload stable until ACK.
  - Deassert REQ_VALID or present a new request on the cycle after ACK.
  - Withdrawal before ACK is illegal.
- WR_REQ:
  - AWVALID and WVALID rise on the same cycle as REQ_ACK.
  - Each channel drops independently on the cycle after its handshake (VALID & READY).
  - Once both handshakes have occurred, including on the same cycle, the next state is WR_RESP.
  - VALIDs never drop before their handshake.
- WR_RESP: BREADY = 1. On BVALID, capture BRESP[1]; next state is DONE.
- RD_REQ: ARVALID = 1 until ARREADY; next state is RD_RESP.
- RD_RESP: RREADY = 1. On RVALID, capture RDATA and RRESP[1]; next state is DONE.
- BREADY and RREADY are 0 outside their response states.
- DONE:
  - RESP_VALID[grant] = 1 for one cycle; RESP_RDATA and RESP_ERR are valid that cycle.
  - ERR_COUNT += RESP_ERR, saturating at 16'hFFFF.
  - Next state is IDLE.
- RESP_RDATA and RESP_ERR hold their value until the next DONE.
- Latency:
  - Request sampled in IDLE at T → ACK and address VALID(s) at T+1.
  - Response handshake at U → RESP_VALID at U+1 → IDLE at U+2.
  - Earliest re-arbitration is at U+2.
- Fairness: a continuously requesting requester waits at most C_NUM_REQ-1 transactions.
- Only one transaction is outstanding at any time. AW and AR never overlap.
- RESP_RDATA is forced to 0 for write completions.

Test Plan:
- Single write, requester 0, addr 0x88000000, data 0x11111111, strb 0xF, slave ready immediately → ACK[0] at T+1, AW/W handshake at T+1, BVALID OKAY → RESP_VALID = 0001, RESP_ERR = 0.
- Single read, requester 2, addr 0x88000004, slave returns 0x22222222 after 3-cycle RVALID delay → RESP_VALID = 0100, RESP_RDATA = 0x22222222, exactly one AR handshake.
- REQ_VALID = 1111 held continuously from reset for 8 transactions → grant order 0,1,2,3,0,1,2,3; each ACK is a one-hot single pulse.
- WREADY asserted 4 cycles after AWREADY, then the reverse order, then both on the same cycle → AWVALID/WVALID drop independently, one BREADY phase each, no extra beats.
- Slave returns BRESP = 2'b10 twice and RRESP = 2'b11 once → RESP_ERR = 1 on each, ERR_COUNT = 3.
- Reset asserted during WR_RESP → next cycle all VALIDs and READYs = 0, BUSY = 0, rr_ptr = 0; the next request from requester 1 completes normally.
